// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ADDR_W/DATA_W, port id enum, packed command struct, command builder.
package mem_arb_pkg;

  localparam int ADDR_W = 7;  // 128 words
  localparam int DATA_W = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic cmd_t mk_cmd(input logic we,
                                  input logic [ADDR_W-1:0] addr,
                                  input logic [DATA_W-1:0] wdata);
    cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester A/B command+return signals and the memory pins.
// Latency: n/a (wires only).
// Backpressure: requests are held by the clients until the matching gnt.
// Modports: master = arbiter side (drives gnt/rvalid/rdata and memory controls),
//           slave  = environment side (clients plus the memory instance).
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_ren, mem_wen, mem_addr, mem_din,
    input  mem_dout
  );

  modport slave (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-request round-robin picker; remembers the last granted port.
// Latency: grants are combinational from the requests; history updates on the edge.
// Backpressure: a losing requester keeps its request and wins the next tie.
// Ports: i_clk, i_rst (sync, active-high), i_req_a/i_req_b in, o_gnt_a/o_gnt_b out.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  port_e r_last;

  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (!i_rst) begin
      if (i_req_a && i_req_b) begin
        // On a tie the port that won last time yields.
        if (r_last == PORT_A) o_gnt_b = 1'b1;
        else                  o_gnt_a = 1'b1;
      end else begin
        o_gnt_a = i_req_a;
        o_gnt_b = i_req_b;
      end
    end
  end

  // Reset to B so that A wins the first tie after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_last <= PORT_B;
    else if (o_gnt_a) r_last <= PORT_A;
    else if (o_gnt_b) r_last <= PORT_B;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 128x8 sync single-port memory between ports A and B.
// Latency: gnt in n (comb), memory command in n+1, read data/rvalid on the issuing port in n+2.
// Backpressure: a loser holds req until gnt; one command accepted per cycle, no bubbles.
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.master: A/B requesters + memory pins).
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_any_gnt;
  cmd_t              w_cmd;

  logic              r_ren;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  // Return tag pipeline: stage 1 travels with the memory command, stage 2
  // lines up with the registered memory output.
  logic              r_s1_vld;
  port_e             r_s1_port;
  logic              r_s2_vld;
  port_e             r_s2_port;

  logic              w_a_rvld;
  logic              w_b_rvld;

  rr_pick2 u_pick (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req_a (bus.a_req),
    .i_req_b (bus.b_req),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign w_any_gnt = w_gnt_a | w_gnt_b;

  always_comb begin
    w_cmd = '0;
    if (w_gnt_a)      w_cmd = mk_cmd(bus.a_we, bus.a_addr, bus.a_wdata);
    else if (w_gnt_b) w_cmd = mk_cmd(bus.b_we, bus.b_addr, bus.b_wdata);
  end

  // Command register: idles to all-zero when nothing is granted. ren and wen
  // are derived from a single we bit, so they can never both be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ren  <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_any_gnt) begin
      r_ren  <= ~w_cmd.we;
      r_wen  <= w_cmd.we;
      r_addr <= w_cmd.addr;
      r_din  <= w_cmd.we ? w_cmd.wdata : '0;
    end else begin
      r_ren  <= 1'b0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end
  end

  // Reset clears both stages, which drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_port <= PORT_A;
      r_s2_vld  <= 1'b0;
      r_s2_port <= PORT_A;
    end else begin
      r_s1_vld  <= w_any_gnt & ~w_cmd.we;
      r_s1_port <= w_gnt_b ? PORT_B : PORT_A;
      r_s2_vld  <= r_s1_vld;
      r_s2_port <= r_s1_port;
    end
  end

  assign w_a_rvld = r_s2_vld && (r_s2_port == PORT_A);
  assign w_b_rvld = r_s2_vld && (r_s2_port == PORT_B);

  assign bus.a_gnt    = w_gnt_a;
  assign bus.b_gnt    = w_gnt_b;
  assign bus.a_rvalid = w_a_rvld;
  assign bus.b_rvalid = w_b_rvld;
  // Memory output is only forwarded to the tagged port; stale dout never leaks.
  assign bus.a_rdata  = w_a_rvld ? bus.mem_dout : '0;
  assign bus.b_rdata  = w_b_rvld ? bus.mem_dout : '0;

  assign bus.mem_ren  = r_ren;
  assign bus.mem_wen  = r_wen;
  assign bus.mem_addr = r_addr;
  assign bus.mem_din  = r_din;

endmodule
